// File: rtl/hash_search_dispatcher.sv
// Stride-interleaved preimage search controller: engine k walks k, k+N, k+2N... over DIGITS-digit ASCII decimals.
// One cycle of dispatch overhead per candidate; engines throttle the search through their start/done handshake.
module hash_search_dispatcher #(
  parameter int NUM_ENG = 5,
  parameter int DIGITS  = 9,
  parameter int HASH_W  = 256,
  parameter int TIMER_W = 56
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [HASH_W-1:0]             target_hash,
  output logic [NUM_ENG-1:0]            eng_start,
  output logic [NUM_ENG*8*DIGITS-1:0]   eng_text,
  input  logic [NUM_ENG-1:0]            eng_done,
  input  logic [NUM_ENG*HASH_W-1:0]     eng_hash,
  output logic                          busy,
  output logic                          found,
  output logic                          not_found,
  output logic [8*DIGITS-1:0]           answer,
  output logic [TIMER_W-1:0]            cycles,
  output logic [8*DIGITS-1:0]           progress
);

  localparam int TW = 8 * DIGITS;
  localparam logic [4:0] STEP = 5'(NUM_ENG);

  typedef enum logic [1:0] {IDLE, RUN, FOUND, EXHAUSTED} state_t;

  state_t             state;
  logic [HASH_W-1:0]  target;
  logic [TW-1:0]      text_q   [NUM_ENG];
  logic [TW-1:0]      text_inc [NUM_ENG];
  logic [NUM_ENG-1:0] carry_out;
  logic [NUM_ENG-1:0] outstanding;
  logic [NUM_ENG-1:0] retire;
  logic [NUM_ENG-1:0] retire_nxt;
  logic [NUM_ENG-1:0] done_ok;
  logic [NUM_ENG-1:0] hit;
  logic               hit_any;
  logic [TW-1:0]      hit_text;

  // Decimal add of NUM_ENG with ripple carry; the top bit is the carry out of the MSD.
  function automatic logic [TW:0] bcd_add(input logic [TW-1:0] txt);
    logic [TW-1:0] res;
    logic [4:0]    s;
    logic          cy;
    res = '0;
    cy  = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      s  = 5'(txt[8*d +: 8] - 8'h30) + ((d == 0) ? STEP : {4'b0, cy});
      cy = (s >= 5'd10);
      res[8*d +: 8] = {4'h3, cy ? 4'(s - 5'd10) : s[3:0]};
    end
    return {cy, res};
  endfunction

  function automatic logic [TW-1:0] init_text(input int k);
    logic [TW-1:0] t;
    t      = {DIGITS{8'h30}};
    t[7:0] = 8'h30 + 8'(k);
    return t;
  endfunction

  always_comb begin
    done_ok  = (state == RUN) ? (eng_done & outstanding) : '0;
    hit      = '0;
    hit_text = '0;
    for (int k = 0; k < NUM_ENG; k++) begin
      {carry_out[k], text_inc[k]} = bcd_add(text_q[k]);
      hit[k] = done_ok[k] && (eng_hash[k*HASH_W +: HASH_W] == target);
    end
    // Descending scan so the lowest matching engine wins.
    for (int k = NUM_ENG - 1; k >= 0; k--) begin
      if (hit[k]) hit_text = text_q[k];
    end
    hit_any    = |hit;
    retire_nxt = retire | (done_ok & carry_out);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      target      <= '0;
      outstanding <= '0;
      retire      <= '0;
      eng_start   <= '0;
      busy        <= 1'b0;
      found       <= 1'b0;
      not_found   <= 1'b0;
      answer      <= '0;
      cycles      <= '0;
      for (int k = 0; k < NUM_ENG; k++) text_q[k] <= {DIGITS{8'h30}};
    end else begin
      eng_start <= '0;
      if (state == RUN && cycles != {TIMER_W{1'b1}}) cycles <= cycles + 1'b1;
      case (state)
        RUN: begin
          if (abort) begin
            state       <= IDLE;
            busy        <= 1'b0;
            outstanding <= '0;
          end else if (hit_any) begin
            state       <= FOUND;
            busy        <= 1'b0;
            found       <= 1'b1;
            answer      <= hit_text;
            outstanding <= '0;
          end else if (&retire_nxt) begin
            state       <= EXHAUSTED;
            busy        <= 1'b0;
            not_found   <= 1'b1;
            retire      <= retire_nxt;
            outstanding <= '0;
          end else begin
            retire      <= retire_nxt;
            outstanding <= outstanding & ~(done_ok & carry_out);
            for (int k = 0; k < NUM_ENG; k++) begin
              if (done_ok[k] && !carry_out[k]) begin
                text_q[k]    <= text_inc[k];
                eng_start[k] <= 1'b1;
              end
            end
          end
        end
        default: begin
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            target      <= target_hash;
            cycles      <= '0;
            found       <= 1'b0;
            not_found   <= 1'b0;
            retire      <= '0;
            outstanding <= '1;
            eng_start   <= '1;
            for (int k = 0; k < NUM_ENG; k++) text_q[k] <= init_text(k);
          end
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_ENG; k++) begin : g_text
    assign eng_text[k*TW +: TW] = text_q[k];
  end
  assign progress = text_q[NUM_ENG-1];

endmodule

// File: tb/tb_hash_search_dispatcher.sv
// Bench for hash_search_dispatcher: two instances (N=3/D=2 and N=7/D=3) driven by stub engines
// whose hash is the candidate text and whose done arrives exactly 4 cycles after eng_start.
module tb_hash_search_dispatcher;

  localparam int NA = 3, DA = 2, HA = 16, TA = 8;
  localparam int NB = 7, DB = 3, HB = 24, TB = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_a, start_a, abort_a;
  logic [HA-1:0]        target_a;
  logic [NA-1:0]        a_eng_start, a_eng_done, a_force;
  logic [NA*8*DA-1:0]   a_eng_text;
  logic [NA*HA-1:0]     a_eng_hash;
  logic                 a_busy, a_found, a_nf;
  logic [8*DA-1:0]      a_answer, a_progress;
  logic [TA-1:0]        a_cycles;

  logic                 reset_b, start_b, abort_b;
  logic [HB-1:0]        target_b;
  logic [NB-1:0]        b_eng_start, b_eng_done;
  logic [NB*8*DB-1:0]   b_eng_text;
  logic [NB*HB-1:0]     b_eng_hash;
  logic                 b_busy, b_found, b_nf;
  logic [8*DB-1:0]      b_answer, b_progress;
  logic [TB-1:0]        b_cycles;

  hash_search_dispatcher #(.NUM_ENG(NA), .DIGITS(DA), .HASH_W(HA), .TIMER_W(TA)) dut_a (
    .clk(clk), .reset(reset_a), .start(start_a), .abort(abort_a), .target_hash(target_a),
    .eng_start(a_eng_start), .eng_text(a_eng_text), .eng_done(a_eng_done), .eng_hash(a_eng_hash),
    .busy(a_busy), .found(a_found), .not_found(a_nf), .answer(a_answer), .cycles(a_cycles),
    .progress(a_progress));

  hash_search_dispatcher #(.NUM_ENG(NB), .DIGITS(DB), .HASH_W(HB), .TIMER_W(TB)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .abort(abort_b), .target_hash(target_b),
    .eng_start(b_eng_start), .eng_text(b_eng_text), .eng_done(b_eng_done), .eng_hash(b_eng_hash),
    .busy(b_busy), .found(b_found), .not_found(b_nf), .answer(b_answer), .cycles(b_cycles),
    .progress(b_progress));

  // Stub engines: counter 1..4 after a start; done while the counter reads 4.
  int a_cnt [NA];
  int b_cnt [NB];

  always @(posedge clk) begin
    for (int k = 0; k < NA; k++) begin
      if (reset_a)                a_cnt[k] <= 0;
      else if (a_eng_start[k])    a_cnt[k] <= 1;
      else if (a_cnt[k] == 4)     a_cnt[k] <= 0;
      else if (a_cnt[k] != 0)     a_cnt[k] <= a_cnt[k] + 1;
    end
    for (int k = 0; k < NB; k++) begin
      if (reset_b)                b_cnt[k] <= 0;
      else if (b_eng_start[k])    b_cnt[k] <= 1;
      else if (b_cnt[k] == 4)     b_cnt[k] <= 0;
      else if (b_cnt[k] != 0)     b_cnt[k] <= b_cnt[k] + 1;
    end
  end

  always_comb begin
    for (int k = 0; k < NA; k++) begin
      a_eng_done[k] = (a_cnt[k] == 4);
      a_eng_hash[k*HA +: HA] = a_force[k] ? target_a : a_eng_text[k*16 +: 16];
    end
    for (int k = 0; k < NB; k++) begin
      b_eng_done[k] = (b_cnt[k] == 4);
      b_eng_hash[k*HB +: HB] = b_eng_text[k*24 +: 24];
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_dut_a();
    reset_a = 1'b1; start_a = 1'b0; abort_a = 1'b0;
    step(); step();
    reset_a = 1'b0;
  endtask

  typedef struct {
    logic [15:0] target;
    logic [2:0]  force_m;
    logic        exp_found;
    logic        exp_nf;
    logic [15:0] exp_answer;
    int          exp_cyc;
    logic [7:0]  exp_cycles;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    logic any_start;
    logic seen091, seen098, seen105;
    logic [23:0] last0, last6, t0;
    int  starts0;

    tbl[0] = '{16'h3037, 3'b000, 1'b1, 1'b0, 16'h3037,  16,  8'd15};
    tbl[1] = '{16'h4142, 3'b000, 1'b0, 1'b1, 16'h0000, 171, 8'd170};
    tbl[2] = '{16'h3030, 3'b000, 1'b1, 1'b0, 16'h3030,   6,  8'd5};
    tbl[3] = '{16'h3939, 3'b000, 1'b1, 1'b0, 16'h3939, 171, 8'd170};
    tbl[4] = '{16'h3938, 3'b000, 1'b1, 1'b0, 16'h3938, 166, 8'd165};
    tbl[5] = '{16'h4142, 3'b110, 1'b1, 1'b0, 16'h3031,   6,  8'd5};
    tbl[6] = '{16'h4142, 3'b100, 1'b1, 1'b0, 16'h3032,   6,  8'd5};

    a_force = '0; target_a = '0;
    reset_b = 1'b1; start_b = 1'b0; abort_b = 1'b0; target_b = '0;
    reset_dut_a();

    check("rst_busy", a_busy, 0);
    check("rst_found", a_found, 0);
    check("rst_not_found", a_nf, 0);
    check("rst_eng_start", a_eng_start, 0);
    check("rst_answer", a_answer, 0);
    check("rst_cycles", a_cycles, 0);
    check("rst_eng_text", a_eng_text, 48'h303030303030);
    check("rst_progress", a_progress, 16'h3030);

    for (int i = 0; i < 7; i++) begin
      reset_dut_a();
      a_force = tbl[i].force_m;
      target_a = tbl[i].target;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      cyc = 1;
      while (!(a_found || a_nf) && cyc < 400) begin
        step();
        cyc++;
      end
      check($sformatf("vec%0d_found", i), a_found, tbl[i].exp_found);
      check($sformatf("vec%0d_not_found", i), a_nf, tbl[i].exp_nf);
      check($sformatf("vec%0d_answer", i), a_answer, tbl[i].exp_answer);
      check($sformatf("vec%0d_cycle", i), cyc, tbl[i].exp_cyc);
      check($sformatf("vec%0d_cycles", i), a_cycles, tbl[i].exp_cycles);
      check($sformatf("vec%0d_busy", i), a_busy, 0);
    end
    a_force = '0;

    // Launch timing, start-while-busy, stride walk, then reset mid-run.
    reset_dut_a();
    target_a = 16'h3037;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("c1_busy", a_busy, 1);
    check("c1_eng_start", a_eng_start, 3'b111);
    check("c1_eng_text", a_eng_text, 48'h303230313030);
    check("c1_progress", a_progress, 16'h3032);
    check("c1_cycles", a_cycles, 0);
    step(); step();
    start_a = 1'b1; target_a = 16'h3030;
    step();
    start_a = 1'b0; target_a = 16'h3037;
    check("busy_start_text", a_eng_text, 48'h303230313030);
    check("busy_start_eng_start", a_eng_start, 0);
    check("busy_start_cycles", a_cycles, 3);
    step(); step();
    check("c6_eng_start", a_eng_start, 3'b111);
    check("c6_eng_text", a_eng_text, 48'h303530343033);
    check("c6_found", a_found, 0);
    repeat (5) step();
    check("c11_eng1_text", a_eng_text[16 +: 16], 16'h3037);
    step();
    reset_a = 1'b1;
    step();
    reset_a = 1'b0;
    check("midrst_busy", a_busy, 0);
    check("midrst_found", a_found, 0);
    check("midrst_not_found", a_nf, 0);
    check("midrst_eng_start", a_eng_start, 0);
    check("midrst_cycles", a_cycles, 0);
    check("midrst_eng_text", a_eng_text, 48'h303030303030);
    check("midrst_progress", a_progress, 16'h3030);

    // Abort at cycle 8, late done ignored, then restart.
    reset_dut_a();
    target_a = 16'h4142;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (7) step();
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    check("abort_busy", a_busy, 0);
    check("abort_found", a_found, 0);
    check("abort_not_found", a_nf, 0);
    check("abort_cycles", a_cycles, 8);
    any_start = 1'b0;
    for (int c = 9; c <= 20; c++) begin
      any_start = any_start | (|a_eng_start);
      step();
    end
    check("abort_no_restart", any_start, 0);
    check("abort_cycles_held", a_cycles, 8);
    check("abort_nf_held", a_nf, 0);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("restart_eng_start", a_eng_start, 3'b111);
    check("restart_eng_text", a_eng_text, 48'h303230313030);
    check("restart_busy", a_busy, 1);

    // N=7, D=3 full walk to exhaustion with a 6-bit saturating timer.
    step(); step();
    reset_b = 1'b0;
    target_b = 24'h414243;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    check("b_c1_eng_text0", b_eng_text[0 +: 24], 24'h303030);
    check("b_c1_eng_text6", b_eng_text[6*24 +: 24], 24'h303036);
    seen091 = 1'b0; seen098 = 1'b0; seen105 = 1'b0;
    last0 = '0; last6 = '0; starts0 = 0;
    cyc = 1;
    while (!(b_found || b_nf) && cyc < 1500) begin
      if (b_eng_start[0]) begin
        t0 = b_eng_text[0 +: 24];
        starts0++;
        if (t0 == 24'h303931) seen091 = 1'b1;
        if (t0 == 24'h303938) seen098 = 1'b1;
        if (t0 == 24'h313035) seen105 = 1'b1;
        last0 = t0;
      end
      if (b_eng_start[6]) last6 = b_eng_text[6*24 +: 24];
      step();
      cyc++;
    end
    check("b_seen_091", seen091, 1);
    check("b_seen_098", seen098, 1);
    check("b_seen_105", seen105, 1);
    check("b_eng0_last", last0, 24'h393934);
    check("b_eng6_last", last6, 24'h393933);
    check("b_eng0_count", starts0, 143);
    check("b_done_cycle", cyc, 716);
    check("b_not_found", b_nf, 1);
    check("b_found", b_found, 0);
    check("b_busy", b_busy, 0);
    check("b_cycles_sat", b_cycles, 6'h3f);
    check("b_answer", b_answer, 0);
    check("b_progress", b_progress, 24'h393933);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hash_search_dispatcher.md
# hash_search_dispatcher

Parametrised brute-force preimage search controller that drives NUM_ENG external hash engines over the full DIGITS-digit ASCII decimal space. It sits between the top-level UI FSM (button/LCD) and the hash engine instances. It replaces fixed five-way slicing with stride interleaving, a start/done handshake per engine, exhaustion detection (not_found), abort, and a saturating cycle counter.

## Interface
- NUM_ENG, 5, number of hash engines (1..9)
- DIGITS, 9, decimal digits per candidate (1..16); candidate text is 8*DIGITS bits, MSD in the top byte
- HASH_W, 256, hash width
- TIMER_W, 56, cycle counter width
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a search (ignored while busy)
- abort  in  1  stops a running search, returns to IDLE
- target_hash  in  HASH_W  sampled on accepted start
- eng_start  out  NUM_ENG  per-engine one-cycle launch pulse
- eng_text  out  NUM_ENG*8*DIGITS  candidate for engine k at slice k; stable from eng_start[k] until eng_done[k]
- eng_done  in  NUM_ENG  per-engine one-cycle completion pulse
- eng_hash  in  NUM_ENG*HASH_W  hash of engine k, valid while eng_done[k]=1
- busy  out  1  high in RUN
- found  out  1  match found; held until next start or reset
- not_found  out  1  space exhausted without a match; held as found
- answer  out  8*DIGITS  matching candidate (valid when found)
- cycles  out  TIMER_W  RUN cycle count, saturates at all-ones
- progress  out  8*DIGITS  current candidate of engine NUM_ENG-1, for display

## Operation
- States: IDLE, RUN, FOUND, EXHAUSTED. Reset -> IDLE.
- IDLE/FOUND/EXHAUSTED + start -> RUN. Latch target, clear cycles/found/not_found/retire mask, load eng_text[k] = value k as DIGITS ASCII digits, pulse eng_start = all-ones.
- Engine k tests k, k+N, k+2N, …, where N=NUM_ENG. The next candidate is a BCD ASCII add of N with ripple carry across all digits.
- RUN, eng_done[k] with eng_hash[k]==target: go to FOUND, answer <= eng_text[k]. If several engines match in the same cycle, the lowest k wins.
- RUN, eng_done[k] without a match:
  - If the increment carries out of the MSD, set retire[k]; engine k is never started again.
  - Otherwise update eng_text[k] and pulse eng_start[k] the next cycle.
- RUN, all retire bits set and no match this cycle -> EXHAUSTED, not_found=1.
- RUN + abort -> IDLE. found/not_found stay 0 and cycles holds. eng_done arriving in IDLE/FOUND/EXHAUSTED is ignored and causes no eng_start.
- Priority in RUN: reset > abort > match > exhaustion > continue. start while in RUN is ignored.
- cycles increments every RUN cycle and saturates at 2^TIMER_W-1.
- eng_done[k] for an engine without an outstanding start is ignored.

## Timing
- Reset values: busy=0, found=0, not_found=0, eng_start=0, answer=0, cycles=0, eng_text=all ASCII "0", progress=all ASCII "0".
- Accepted start at cycle t: busy=1, eng_start=all-ones, and new eng_text all appear at t+1.
- eng_done[k] at u without a match: eng_text[k] updates and eng_start[k]=1 at u+1. Dispatcher overhead is 1 cycle per candidate.
- Match at u: found=1, answer valid, busy=0, eng_start=0 at u+1. cycles counts RUN cycles up to and including u.
- Final retirement at u: not_found=1, busy=0 at u+1.
- All outputs are registered. No combinational path from inputs to outputs.
- Reset mid-RUN: next cycle is IDLE with all outputs at reset values.

## Test plan
Bench uses a stub engine: hash = zero-extended text, done exactly 4 cycles after eng_start.
- N=3, D=2, target="07", start at cycle 0 -> engine 1 sees "01","04","07"; found=1 and answer="07" at cycle 16; cycles=15.
- N=3, D=2, target="AB" (not in space) -> engine 0 retires after "99" (34 candidates); not_found=1 at cycle 171; found=0.
- N=7, D=3, engine 0 walk -> eng_text sequence includes "091","098","105"; retires after "994"; engine 6 last candidate "993".
- Two engines forced to match in the same cycle (stub returns target for k=1 and k=2) -> answer = engine 1 text.
- Abort at cycle 8 of a run -> busy=0 at 9; a later eng_done produces no eng_start; found=not_found=0; cycles held at 8. New start restarts from "00","01","02".
- Reset asserted mid-RUN -> all outputs at reset values next cycle. start while busy=1 has no effect on eng_text or cycles.
